// File: rtl/sfp_seq_pkg.sv
// sfp_seq_pkg: shared constants for the sfp_row sequencer.
//   - FSM state encoding (kept as plain 3-bit constants so older tools and
//     waveform decoders that expect raw codes keep working)
//   - sfp_row FIFO depth (upper bound on vectors per job)
//   - DRAIN length (sfp_row sum register + FIFO write)
//   - sync timeout counter width
//   - counter bank indices used by the top
package sfp_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACC   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_SYNC  = 3'd3;
    localparam logic [2:0] ST_DIV   = 3'd4;
    localparam logic [2:0] ST_FLUSH = 3'd5;

    localparam int FIFO_DEPTH = 16;
    localparam int DRAIN_LEN  = 2;
    localparam int TO_BW      = 8;

    // Counter bank slots.
    localparam int CNT_ACC  = 0;
    localparam int CNT_DIV  = 1;
    localparam int CNT_NORM = 2;
    localparam int CNT_NUM  = 3;

    // A job must fit in the sfp_row FIFO and carry at least one vector.
    function automatic logic num_vec_legal(input logic [31:0] n);
        return (n >= 32'd1) && (n <= 32'(FIFO_DEPTH));
    endfunction

endpackage

// File: rtl/sfp_seq_if.sv
// sfp_seq_if: sequencer <-> datapath bundle.
//   ofifo_valid  array output FIFO holds at least one vector
//   ofifo_rd     pop array output FIFO
//   acc          sfp_row acc
//   div          sfp_row div
//   fifo_ext_rd  sfp_row fifo_ext_rd
//   norm_wr      sfp_row per-lane normalized writeback strobes
// master = sequencer side, slave = datapath/FIFO side.
interface sfp_seq_if #(
    parameter int col = 8
);
    logic           ofifo_valid;
    logic           ofifo_rd;
    logic           acc;
    logic           div;
    logic           fifo_ext_rd;
    logic [col-1:0] norm_wr;

    modport master (
        input  ofifo_valid,
        input  norm_wr,
        output ofifo_rd,
        output acc,
        output div,
        output fifo_ext_rd
    );

    modport slave (
        output ofifo_valid,
        output norm_wr,
        input  ofifo_rd,
        input  acc,
        input  div,
        input  fifo_ext_rd
    );
endinterface

// File: rtl/sfp_seq_cnt.sv
// sfp_seq_cnt: cnt_bw-bit up counter with synchronous clear (priority over
// enable) and an equality compare against a terminal value.
//   clk, reset  clock, asynchronous active-low reset
//   clr         clear to zero on next edge
//   en          increment on next edge
//   term        terminal value for the compare
//   cnt         current count
//   at_term     cnt == term
module sfp_seq_cnt #(
    parameter int cnt_bw = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [cnt_bw-1:0] term,
    output logic [cnt_bw-1:0] cnt,
    output logic              at_term
);

    logic [cnt_bw-1:0] cnt_q;
    logic [cnt_bw-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + cnt_bw'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_term = (cnt_q == term);

endmodule

// File: rtl/sfp_seq.sv
// sfp_seq: initiator that drives one sfp_row normalizer.
// Pulls num_vec psum vectors from the array output FIFO (ACC), lets the row
// finish its sum (DRAIN), handshakes with the peer core (SYNC) so both cores
// divide on the same edges, streams the divides (DIV) and waits for the
// normalized writebacks (FLUSH).
//   clk, reset   clock, asynchronous active-low reset
//   start        launch pulse, sampled only in IDLE
//   num_vec      vectors per job (1..16), sampled with start
//   row          sfp_seq_if master: ofifo_valid/ofifo_rd, acc, div,
//                fifo_ext_rd, norm_wr
//   rdy_out      to peer: local sums stored (state SYNC)
//   rdy_in       from peer rdy_out
//   busy         any state but IDLE
//   done         one-cycle pulse on job completion
//   err          one-cycle pulse: illegal start, sync timeout, partial norm_wr
module sfp_seq
    import sfp_seq_pkg::*;
#(
    parameter int col     = 8,
    parameter int cnt_bw  = 5,
    parameter int sync_to = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [cnt_bw-1:0] num_vec,
    sfp_seq_if.master         row,
    output logic              rdy_out,
    input  logic              rdy_in,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [col-1:0]   NORM_ALL   = '1;
    localparam logic [TO_BW-1:0] TO_LIMIT   = TO_BW'(sync_to);
    localparam logic [TO_BW-1:0] TO_MAX     = '1;
    localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_LEN - 1);

    logic [2:0]        state_q, state_d;
    logic [cnt_bw-1:0] nv_q, nv_d;
    logic [TO_BW-1:0]  to_cnt_q, to_cnt_d;
    logic [1:0]        drain_cnt_q, drain_cnt_d;
    logic              err_q, err_d;

    logic              job_start;
    logic              acc_fire;
    logic              in_div;
    logic              norm_full;
    logic              norm_partial;
    logic              done_hit;

    // Counter bank: acc_cnt, div_cnt, norm_cnt.
    logic [CNT_NUM-1:0] cnt_en;
    logic [cnt_bw-1:0]  cnt_term [CNT_NUM];
    logic [cnt_bw-1:0]  cnt_val  [CNT_NUM];
    logic [CNT_NUM-1:0] cnt_hit;

    assign cnt_en[CNT_ACC]    = acc_fire;
    assign cnt_en[CNT_DIV]    = in_div;
    assign cnt_en[CNT_NORM]   = norm_full;
    assign cnt_term[CNT_ACC]  = nv_q;
    // DIV compares against nv-1 so the hit marks the last div cycle itself.
    assign cnt_term[CNT_DIV]  = nv_q - cnt_bw'(1);
    assign cnt_term[CNT_NORM] = nv_q;

    genvar gi;
    generate
        for (gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
            sfp_seq_cnt #(
                .cnt_bw (cnt_bw)
            ) u_cnt (
                .clk     (clk),
                .reset   (reset),
                .clr     (job_start),
                .en      (cnt_en[gi]),
                .term    (cnt_term[gi]),
                .cnt     (cnt_val[gi]),
                .at_term (cnt_hit[gi])
            );
        end
    endgenerate

    assign acc_fire     = (state_q == ST_ACC) && row.ofifo_valid
                          && (cnt_val[CNT_ACC] < nv_q);
    assign in_div       = (state_q == ST_DIV);
    assign norm_full    = (row.norm_wr == NORM_ALL);
    assign norm_partial = (row.norm_wr != '0) && !norm_full;

    // The last writeback lands in the first FLUSH cycle; counting it
    // combinationally lets done fire in that same cycle.
    assign done_hit = cnt_hit[CNT_NORM]
                      || (norm_full && ((cnt_val[CNT_NORM] + cnt_bw'(1)) == nv_q));

    always_comb begin
        state_d     = state_q;
        nv_d        = nv_q;
        to_cnt_d    = to_cnt_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = 1'b0;
        job_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_vec_legal(32'(num_vec))) begin
                        nv_d      = num_vec;
                        job_start = 1'b1;
                        to_cnt_d  = '0;
                        state_d   = ST_ACC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ACC: begin
                if (cnt_hit[CNT_ACC]) begin
                    drain_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_SYNC;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            ST_SYNC: begin
                if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + TO_BW'(1);
                end
                // The peer evaluates the same rdy pair, so both leave SYNC
                // on the same edge.
                if (rdy_in) begin
                    state_d = ST_DIV;
                end else if (to_cnt_q == TO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (cnt_hit[CNT_DIV]) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (done_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (norm_partial) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            nv_q        <= '0;
            to_cnt_q    <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nv_q        <= nv_d;
            to_cnt_q    <= to_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
        end
    end

    assign row.acc         = acc_fire;
    assign row.ofifo_rd    = acc_fire;
    assign row.div         = in_div;
    assign row.fifo_ext_rd = in_div;
    assign rdy_out         = (state_q == ST_SYNC);
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_FLUSH) && done_hit;
    assign err             = err_q;

endmodule

// File: tb/tb_sfp_seq.sv
// tb_sfp_seq: directed bench for sfp_seq. Two sequencers cross-connected on
// rdy for the lock-step job; other jobs run core A against a bench-driven
// rdy_in. A one-cycle delay of div stands in for the sfp_row writeback path.
module tb_sfp_seq;

    localparam int COL = 8;
    localparam int CBW = 5;

    logic           clk;
    logic           reset;
    logic           start_a, start_b;
    logic [CBW-1:0] num_vec_r;
    logic           ov_a, ov_b;
    logic           tb_rdy;
    logic           peer_mode;
    logic           part_a;
    logic           div_d_a, div_d_b;

    logic rdy_out_a, rdy_out_b, rdy_in_a, rdy_in_b;
    logic busy_a, busy_b, done_a, done_b, err_a, err_b;

    sfp_seq_if #(.col(COL)) if_a ();
    sfp_seq_if #(.col(COL)) if_b ();

    assign if_a.ofifo_valid = ov_a;
    assign if_b.ofifo_valid = ov_b;
    assign if_a.norm_wr     = part_a ? 8'h0F : {COL{div_d_a}};
    assign if_b.norm_wr     = {COL{div_d_b}};
    assign rdy_in_a         = peer_mode ? rdy_out_b : tb_rdy;
    assign rdy_in_b         = rdy_out_a;

    sfp_seq #(.col(COL), .cnt_bw(CBW), .sync_to(255)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .num_vec(num_vec_r),
        .row(if_a), .rdy_out(rdy_out_a), .rdy_in(rdy_in_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    sfp_seq #(.col(COL), .cnt_bw(CBW), .sync_to(255)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .num_vec(num_vec_r),
        .row(if_b), .rdy_out(rdy_out_b), .rdy_in(rdy_in_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    // sfp_row writeback: norm_wr one cycle after div, cleared by the same reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_d_a <= 1'b0;
            div_d_b <= 1'b0;
        end else begin
            div_d_a <= if_a.div;
            div_d_b <= if_b.div;
        end
    end

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-job observations (core A unless suffixed _b).
    int n_acc, first_acc, acc_bad, n_div_a, n_div_b, first_div_a, ab_diff;
    int n_rdy, first_rdy, n_done, done_cyc, n_done_b, done_cyc_b;
    int n_err, err_cyc, n_busy, timed_out, post_err, post_busy;
    int post_div, post_fer, post_rdy;

    // rdy_mode: 0 = peer core, 1 = bench rdy from cycle rdy_at, 2 = never.
    task automatic run_job(input int nv, input int ov_mode, input int rdy_mode,
                           input int rdy_at, input bit use_b, input int max_cyc,
                           input int start_div_at, input int partial_at,
                           input int abort_div);
        bit aborted;
        aborted = 0;
        n_acc = 0; first_acc = -1; acc_bad = 0; n_div_a = 0; n_div_b = 0;
        first_div_a = -1; ab_diff = 0; n_rdy = 0; first_rdy = -1;
        n_done = 0; done_cyc = -1; n_done_b = 0; done_cyc_b = -1;
        n_err = 0; err_cyc = -1; n_busy = 0; timed_out = 1;
        post_err = -1; post_busy = -1; post_div = -1; post_fer = -1; post_rdy = -1;
        peer_mode = (rdy_mode == 0);
        num_vec_r = CBW'(nv);
        start_a = 1'b1;
        start_b = use_b;
        for (int c = 0; c < max_cyc; c++) begin
            if (c > 0) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            ov_a   = (ov_mode == 0) ? 1'b1 : ((c % 2) == 1);
            ov_b   = 1'b1;
            tb_rdy = (rdy_mode == 1) && (c >= rdy_at);
            part_a = (c == partial_at);
            if (start_div_at > 0 && c == start_div_at) begin
                start_a   = 1'b1;
                num_vec_r = CBW'(2);
            end
            #1;
            if (if_a.acc) begin
                n_acc++;
                if (first_acc < 0) first_acc = c;
                if (!ov_a) acc_bad++;
            end
            if (if_a.ofifo_rd != if_a.acc) acc_bad++;
            if (if_a.fifo_ext_rd != if_a.div) acc_bad++;
            if (if_a.div) begin
                n_div_a++;
                if (first_div_a < 0) first_div_a = c;
            end
            if (if_b.div) n_div_b++;
            if (use_b && (if_a.div != if_b.div)) ab_diff++;
            if (rdy_out_a) begin
                n_rdy++;
                if (first_rdy < 0) first_rdy = c;
            end
            if (done_a) begin n_done++; done_cyc = c; end
            if (done_b) begin n_done_b++; done_cyc_b = c; end
            if (err_a) begin n_err++; err_cyc = c; end
            if (busy_a) n_busy++;
            if (abort_div > 0 && n_div_a == abort_div) begin
                #1 reset = 1'b0;
                #1;
                post_div  = int'(if_a.div);
                post_fer  = int'(if_a.fifo_ext_rd);
                post_busy = int'(busy_a);
                post_rdy  = int'(rdy_out_a);
                @(negedge clk);
                reset = 1'b1;
                aborted = 1;
                timed_out = 0;
                break;
            end
            if (c > 0 && !busy_a && !busy_b) begin
                timed_out = 0;
                break;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        part_a  = 1'b0;
        if (!aborted) begin
            @(negedge clk);
            #1;
            post_err  = int'(err_a);
            post_busy = int'(busy_a);
            @(negedge clk);
        end
        $display("job nv=%0d acc=%0d div=%0d/%0d rdy=%0d done@%0d err=%0d@%0d",
                 nv, n_acc, n_div_a, n_div_b, n_rdy, done_cyc, n_err, err_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        num_vec_r = '0; ov_a = 1'b1; ov_b = 1'b1; tb_rdy = 1'b0;
        peer_mode = 1'b0; part_a = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",  int'(busy_a), 0);
        chk("rst_acc",   int'(if_a.acc), 0);
        chk("rst_ofrd",  int'(if_a.ofifo_rd), 0);
        chk("rst_div",   int'(if_a.div), 0);
        chk("rst_rdy",   int'(rdy_out_a), 0);
        chk("rst_done",  int'(done_a), 0);
        chk("rst_err",   int'(err_a), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Lock-step pair, nv=4.
        run_job(4, 0, 0, 0, 1, 60, -1, -1, 0);
        chk("ls_timeout",   timed_out, 0);
        chk("ls_acc_n",     n_acc, 4);
        chk("ls_acc_first", first_acc, 1);
        chk("ls_acc_bad",   acc_bad, 0);
        chk("ls_rdy_first", first_rdy, 8);
        chk("ls_rdy_n",     n_rdy, 1);
        chk("ls_div_a",     n_div_a, 4);
        chk("ls_div_b",     n_div_b, 4);
        chk("ls_div_first", first_div_a, 9);
        chk("ls_div_skew",  ab_diff, 0);
        chk("ls_done_a",    done_cyc, 13);
        chk("ls_done_b",    done_cyc_b, 13);
        chk("ls_done_n",    n_done, 1);
        chk("ls_err_n",     n_err, 0);
        chk("ls_post_busy", post_busy, 0);

        // ofifo_valid toggling, nv=3.
        run_job(3, 1, 1, 0, 0, 60, -1, -1, 0);
        chk("tg_timeout",   timed_out, 0);
        chk("tg_acc_n",     n_acc, 3);
        chk("tg_acc_bad",   acc_bad, 0);
        chk("tg_rdy_first", first_rdy, 9);
        chk("tg_div_first", first_div_a, 10);
        chk("tg_div_n",     n_div_a, 3);
        chk("tg_done",      done_cyc, 13);

        // Peer rdy delayed: rdy_out held 10 cycles, DIV right after rdy_in.
        run_job(4, 0, 1, 17, 0, 80, -1, -1, 0);
        chk("dl_timeout",   timed_out, 0);
        chk("dl_rdy_first", first_rdy, 8);
        chk("dl_rdy_n",     n_rdy, 10);
        chk("dl_div_first", first_div_a, 18);
        chk("dl_done",      done_cyc, 22);
        chk("dl_err_n",     n_err, 0);

        // Sync timeout: rdy_in never rises.
        run_job(1, 0, 2, 0, 0, 400, -1, -1, 0);
        chk("to_timeout",   timed_out, 0);
        chk("to_rdy_first", first_rdy, 5);
        chk("to_rdy_len",   int'(n_rdy == 255 || n_rdy == 256), 1);
        chk("to_err_n",     n_err, 1);
        chk("to_err_cyc",   err_cyc, first_rdy + n_rdy);
        chk("to_done_n",    n_done, 0);
        chk("to_div_n",     n_div_a, 0);
        chk("to_post_busy", post_busy, 0);
        chk("to_post_err",  post_err, 0);

        // Illegal starts.
        run_job(0, 0, 1, 0, 0, 10, -1, -1, 0);
        chk("z_err_cyc",  err_cyc, 1);
        chk("z_err_n",    n_err, 1);
        chk("z_busy_n",   n_busy, 0);
        chk("z_post_err", post_err, 0);
        run_job(17, 0, 1, 0, 0, 10, -1, -1, 0);
        chk("o_err_cyc",  err_cyc, 1);
        chk("o_err_n",    n_err, 1);
        chk("o_busy_n",   n_busy, 0);

        // Start during DIV is ignored.
        run_job(4, 0, 1, 0, 0, 60, 9, -1, 0);
        chk("sd_err_n",  n_err, 0);
        chk("sd_div_n",  n_div_a, 4);
        chk("sd_done_n", n_done, 1);
        chk("sd_done",   done_cyc, 13);

        // Partial norm_wr: err pulse, job still completes.
        run_job(2, 0, 1, 0, 0, 60, -1, 2, 0);
        chk("pw_err_cyc", err_cyc, 3);
        chk("pw_err_n",   n_err, 1);
        chk("pw_done",    done_cyc, 9);

        // Reset mid-DIV at div_cnt=2, then a fresh job.
        run_job(4, 0, 1, 0, 0, 60, -1, -1, 3);
        chk("rs_first_div", first_div_a, 9);
        chk("rs_div",  post_div, 0);
        chk("rs_fer",  post_fer, 0);
        chk("rs_busy", post_busy, 0);
        chk("rs_rdy",  post_rdy, 0);
        run_job(2, 0, 1, 0, 0, 60, -1, -1, 0);
        chk("rs2_timeout", timed_out, 0);
        chk("rs2_div_n",   n_div_a, 2);
        chk("rs2_done",    done_cyc, 9);
        chk("rs2_done_n",  n_done, 1);
        chk("rs2_err_n",   n_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
